rom_responder: RTL

ROM-side responder for the 4-bit multiplexed instruction bus. It tracks the 8-phase instruction cycle from SYNC and captures the 12-bit address the CPU drives during A1/A2/A3. When the chip number matches, it fetches a byte from an external synchronous ROM macro and drives OPR/OPA back during M1/M2. It also implements the 4001-style I/O port commands SRC, WRR and RDR.

---
 rtl/rom_responder.sv | 119 +++++++++++
 1 files changed

// File: rtl/rom_responder.sv
// ROM-side responder for the 4-bit multiplexed instruction bus: follows the
// eight-phase cycle, serves instruction bytes from a ROM macro and runs the I/O port.
module rom_responder #(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       SYNC,
  input  logic       CM_ROM,
  input  logic [3:0] DATA_I,
  output logic [3:0] DATA_O,
  output logic       DATA_OE,
  output logic       mem_rd,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  input  logic [3:0] io_in,
  output logic [3:0] io_out
);

  typedef enum logic [3:0] {
    IDLE, A1, A2, A3, M1, M2, X1, X2, X3
  } phase_t;

  phase_t     state;
  logic [3:0] addr_lo;
  logic [3:0] addr_mid;
  logic [3:0] inst_q;
  logic [3:0] opr_q;
  logic [3:0] opa_q;
  logic       sel_q;
  logic       src_sel_q;
  logic       io_cmd_q;

  logic chip_hit;
  logic src_hit;
  logic io_cmd_ok;
  logic wrr_hit;
  logic rdr_hit;

  assign chip_hit  = (DATA_I == CHIP_ID);
  assign src_hit   = (state == X2) && CM_ROM && (opr_q == 4'h2) && opa_q[0];
  assign io_cmd_ok = (state == X2) && io_cmd_q && (opr_q == 4'hE) && src_sel_q;
  assign wrr_hit   = io_cmd_ok && (opa_q == 4'h2);
  assign rdr_hit   = io_cmd_ok && (opa_q == 4'hA);

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state     <= IDLE;
      addr_lo   <= 4'h0;
      addr_mid  <= 4'h0;
      inst_q    <= 4'h0;
      opr_q     <= 4'h0;
      opa_q     <= 4'h0;
      sel_q     <= 1'b0;
      src_sel_q <= 1'b0;
      io_cmd_q  <= 1'b0;
      io_out    <= 4'h0;
    end else begin
      if (SYNC) begin
        state <= A1;
      end else begin
        case (state)
          A1:      state <= A2;
          A2:      state <= A3;
          A3:      state <= M1;
          M1:      state <= M2;
          M2:      state <= X1;
          X1:      state <= X2;
          X2:      state <= X3;
          default: state <= IDLE;
        endcase
      end

      // The opcode snoop runs in every instance so SRC/WRR/RDR decode even
      // when another chip served the instruction byte.
      case (state)
        A1: addr_lo  <= DATA_I;
        A2: addr_mid <= DATA_I;
        A3: sel_q    <= chip_hit;
        M1: begin
          inst_q <= mem_rdata[3:0];
          opr_q  <= DATA_I;
        end
        M2: begin
          opa_q    <= DATA_I;
          io_cmd_q <= CM_ROM;
        end
        X2: begin
          if (src_hit) src_sel_q <= chip_hit;
          if (wrr_hit) io_out    <= DATA_I;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_rd   = (state == A3) && chip_hit;
    mem_addr = (state == A3) ? {addr_mid, addr_lo} : 8'h00;
    DATA_OE  = 1'b0;
    DATA_O   = 4'h0;
    case (state)
      M1: if (sel_q) begin
        DATA_OE = 1'b1;
        DATA_O  = mem_rdata[7:4];
      end
      M2: if (sel_q) begin
        DATA_OE = 1'b1;
        DATA_O  = inst_q;
      end
      X2: if (rdr_hit) begin
        DATA_OE = 1'b1;
        DATA_O  = io_in;
      end
      default: ;
    endcase
  end

endmodule
